pwm_scheduler: RTL and testbench

Multi-channel PWM controller that sequences a shared period counter and drives up to four duty-cycle outputs onto the `uo_out` pins of the tile. The host loads period, duty and enable values into staging registers through a valid/ready write port. The block commits them atomically at a period boundary, so no output ever shows a torn cycle. Start/stop control runs a small state machine that always finishes the current period before halting.

---
 rtl/pwm_scheduler_pkg.sv | 22 ++
 rtl/pwm_scheduler_if.sv | 12 +
 rtl/pwm_scheduler_channel.sv | 32 +++
 rtl/pwm_scheduler.sv | 105 ++++++++++
 tb/tb_pwm_scheduler.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pwm_scheduler_pkg.sv
// Shared types and constants for the PWM scheduler: FSM states, config
// address map and the channel-count ceiling.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    localparam logic [2:0] A_PERIOD = 3'd0;
    localparam logic [2:0] A_EN     = 3'd1;
    localparam logic [2:0] A_COMMIT = 3'd2;
    localparam logic [2:0] A_DUTY0  = 3'd4;

    localparam int MAX_CHANNELS = 4;

    function automatic logic [2:0] duty_addr(input int ch);
        return A_DUTY0 + 3'(ch);
    endfunction

endpackage

// File: rtl/pwm_scheduler_if.sv
// Host configuration write port (valid/ready) of the PWM scheduler.
interface pwm_scheduler_if #(
    parameter int WIDTH = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_addr, input  cfg_data, output cfg_ready);
endinterface

// File: rtl/pwm_scheduler_channel.sv
// One PWM channel: staged/active duty pair and the counter compare.
module pwm_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_cnt,
    input  logic             i_busy,
    input  logic             i_en,
    input  logic             i_commit_now,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_pwm
);
    logic [WIDTH-1:0] r_duty_stg;
    logic [WIDTH-1:0] r_duty_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_stg <= '0;
            r_duty_act <= '0;
        end else begin
            if (i_wr)
                r_duty_stg <= i_data;
            if (i_commit_now)
                r_duty_act <= r_duty_stg;
        end
    end

    assign o_pwm = i_busy && i_en && (i_cnt < r_duty_act);

endmodule

// File: rtl/pwm_scheduler.sv
// Multi-channel PWM: shared period counter, start/stop FSM that always
// completes the running period, and atomic staging->active commit at wrap.
module pwm_scheduler
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    pwm_scheduler_if.slave      cfg,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick,
    output logic                busy
);
    state_t              r_state, w_state_next;
    logic [WIDTH-1:0]    r_cnt, w_cnt_next;
    logic [WIDTH-1:0]    r_period_stg, r_period_act;
    logic [CHANNELS-1:0] r_en_stg, r_en_act;
    logic                r_pending, w_pending_next;
    logic                w_wr, w_commit_wr, w_wrap, w_commit_now;

    assign w_wr         = cfg.cfg_valid && cfg.cfg_ready;
    assign w_commit_wr  = w_wr && (cfg.cfg_addr == A_COMMIT);
    assign busy         = (r_state != IDLE);
    assign w_wrap       = busy && (r_cnt == r_period_act);
    assign period_tick  = w_wrap;
    assign w_commit_now = (w_commit_wr && !busy) || (w_wrap && r_pending);
    // Stalling every write while a commit waits keeps the committed set intact.
    assign cfg.cfg_ready = ~r_pending;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pending_next = r_pending;
        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (start && !stop)
                    w_state_next = RUN;
            end
            RUN: begin
                w_cnt_next = w_wrap ? '0 : r_cnt + WIDTH'(1);
                if (stop)
                    w_state_next = STOPPING;
            end
            STOPPING: begin
                w_cnt_next = w_wrap ? '0 : r_cnt + WIDTH'(1);
                if (start && !stop)
                    w_state_next = RUN;
                else if (w_wrap)
                    w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
        if (w_commit_now)
            w_pending_next = 1'b0;
        else if (w_commit_wr && busy)
            w_pending_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_period_stg <= '0;
            r_period_act <= '0;
            r_en_stg     <= '0;
            r_en_act     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
            if (w_wr && cfg.cfg_addr == A_PERIOD)
                r_period_stg <= cfg.cfg_data;
            if (w_wr && cfg.cfg_addr == A_EN)
                r_en_stg <= cfg.cfg_data[CHANNELS-1:0];
            if (w_commit_now) begin
                r_period_act <= r_period_stg;
                r_en_act     <= r_en_stg;
            end
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        pwm_channel #(.WIDTH(WIDTH)) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_cnt        (r_cnt),
            .i_busy       (busy),
            .i_en         (r_en_act[gi]),
            .i_commit_now (w_commit_now),
            .i_wr         (w_wr && (cfg.cfg_addr == duty_addr(gi))),
            .i_data       (cfg.cfg_data),
            .o_pwm        (pwm_out[gi])
        );
    end

endmodule

// File: tb/tb_pwm_scheduler.sv
// Directed bench for pwm_scheduler: hand-computed waveform expectations per cycle.
module tb_pwm_scheduler;
    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] pwm_out;
    logic       period_tick;
    logic       busy;

    int n_vec = 0;
    int n_bad = 0;

    pwm_scheduler_if #(.WIDTH(8)) cfg_if ();

    pwm_scheduler #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .cfg         (cfg_if),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer one write and wait (bounded) for it to be taken.
    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        logic acc;
        logic rdy;
        acc = 1'b0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = addr;
        cfg_if.cfg_data  = data;
        for (int k = 0; k < 40 && !acc; k++) begin
            rdy = cfg_if.cfg_ready;
            @(negedge clk);
            if (rdy) acc = 1'b1;
        end
        cfg_if.cfg_valid = 1'b0;
        chk("wr_accept", 32'(acc), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        adv(1);
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_pwm;
        int c;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
        adv(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_tick", 32'(period_tick), 0);
        chk("rst_ready", 32'(cfg_if.cfg_ready), 1);
        rst = 1'b0;

        // Basic waveform: period 9, duties 0/3/10/255
        wr(3'd0, 8'd9); wr(3'd1, 8'h0F);
        wr(3'd4, 8'd0); wr(3'd5, 8'd3); wr(3'd6, 8'd10); wr(3'd7, 8'd255);
        wr(3'd2, 8'd0);
        chk("idle_pwm", 32'(pwm_out), 0);
        chk("idle_busy", 32'(busy), 0);
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            c = i % 10;
            exp_pwm = 4'b1100 | ((c < 3) ? 4'b0010 : 4'b0000);
            chk($sformatf("run_pwm_c%0d", c), 32'(pwm_out), 32'(exp_pwm));
            chk($sformatf("run_tick_c%0d", c), 32'(period_tick), 32'(c == 9));
            chk("run_busy", 32'(busy), 1);
            adv(1);
        end

        // Mid-period commit of duty1 = 7, with a write held during the stall
        wr(3'd5, 8'd7);
        chk("stage_no_effect_c1", 32'(pwm_out), 32'h0E);
        wr(3'd2, 8'd0);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_addr = 3'd4; cfg_if.cfg_data = 8'd5;
        for (c = 2; c <= 9; c++) begin
            chk($sformatf("stall_ready_c%0d", c), 32'(cfg_if.cfg_ready), 0);
            exp_pwm = 4'b1100 | ((c < 3) ? 4'b0010 : 4'b0000);
            chk($sformatf("stall_pwm_c%0d", c), 32'(pwm_out), 32'(exp_pwm));
            chk($sformatf("stall_tick_c%0d", c), 32'(period_tick), 32'(c == 9));
            adv(1);
        end
        chk("ready_after_wrap", 32'(cfg_if.cfg_ready), 1);
        adv(1);
        cfg_if.cfg_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            c = i % 10;
            exp_pwm = 4'b1100 | ((c < 7) ? 4'b0010 : 4'b0000);
            chk($sformatf("new_duty_c%0d", c), 32'(pwm_out), 32'(exp_pwm));
            chk("new_ready", 32'(cfg_if.cfg_ready), 1);
            adv(1);
        end

        // Stop at cnt 2: the period completes, busy falls after the tick
        adv(1);
        stop = 1'b1; adv(1); stop = 1'b0;
        for (c = 3; c <= 9; c++) begin
            exp_pwm = 4'b1100 | ((c < 7) ? 4'b0010 : 4'b0000);
            chk($sformatf("stopping_pwm_c%0d", c), 32'(pwm_out), 32'(exp_pwm));
            chk($sformatf("stopping_tick_c%0d", c), 32'(period_tick), 32'(c == 9));
            chk("stopping_busy", 32'(busy), 1);
            adv(1);
        end
        chk("stopped_busy", 32'(busy), 0);
        chk("stopped_pwm", 32'(pwm_out), 0);
        chk("stopped_tick", 32'(period_tick), 0);

        // Start during STOPPING at cnt 5 resumes without a phase jump
        pulse_start();
        adv(2);
        stop = 1'b1; adv(1); stop = 1'b0;
        adv(2);
        pulse_start();
        chk("resume_pwm_c6", 32'(pwm_out), 32'h0E);
        adv(1);
        chk("resume_pwm_c7", 32'(pwm_out), 32'h0C);
        adv(2);
        chk("resume_tick_c9", 32'(period_tick), 1);
        adv(1);
        chk("resume_busy_c0", 32'(busy), 1);
        chk("resume_tick_c0", 32'(period_tick), 0);
        chk("resume_pwm_c0", 32'(pwm_out), 32'h0E);

        // start+stop together: RUN -> STOPPING, IDLE stays IDLE
        start = 1'b1; stop = 1'b1; adv(1); start = 1'b0; stop = 1'b0;
        adv(8);
        chk("both_run_tick_c9", 32'(period_tick), 1);
        chk("both_run_busy_c9", 32'(busy), 1);
        adv(1);
        chk("both_run_idle", 32'(busy), 0);
        start = 1'b1; stop = 1'b1; adv(1); start = 1'b0; stop = 1'b0;
        chk("both_idle_busy", 32'(busy), 0);
        adv(1);
        chk("both_idle_busy2", 32'(busy), 0);

        // Period 0: every cycle wraps
        wr(3'd0, 8'd0); wr(3'd4, 8'd1); wr(3'd5, 8'd0); wr(3'd2, 8'd0);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("p0_pwm_%0d", i), 32'(pwm_out), 32'h0D);
            chk($sformatf("p0_tick_%0d", i), 32'(period_tick), 1);
            chk("p0_busy", 32'(busy), 1);
            adv(1);
        end
        stop = 1'b1; adv(1); stop = 1'b0;
        adv(1);
        chk("p0_stopped", 32'(busy), 0);

        // Reset at cnt 6 with a commit pending
        wr(3'd0, 8'd9); wr(3'd2, 8'd0);
        pulse_start();
        adv(4);
        wr(3'd4, 8'd9); wr(3'd2, 8'd0);
        chk("pend_ready_c6", 32'(cfg_if.cfg_ready), 0);
        chk("pend_pwm_c6", 32'(pwm_out), 32'h0C);
        rst = 1'b1; adv(1); rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pwm", 32'(pwm_out), 0);
        chk("mid_rst_ready", 32'(cfg_if.cfg_ready), 1);
        chk("mid_rst_tick", 32'(period_tick), 0);
        pulse_start();
        chk("post_rst_busy", 32'(busy), 1);
        chk("post_rst_pwm", 32'(pwm_out), 0);
        chk("post_rst_tick", 32'(period_tick), 1);
        adv(1);
        chk("post_rst_pwm2", 32'(pwm_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
